apb_regfile_arbiter: RTL and testbench
======================================

Name: apb_regfile_arbiter

Overview:
- Multi-requester APB master that shares the single APB slave port of a generated register file (e.g. single_sheet_regfile) between NUM_REQ internal agents (CPU bridge, DMA, debug).
- Accepts simple valid/done requests, arbitrates round-robin, and sequences correct APB SETUP/ACCESS phases.
- Returns read data and error status to the granted requester.
- Bounds hung transfers with a pready timeout.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 8, APB address width
- DATA_W, 32, APB data width
- TIMEOUT_CYCLES, 16, ACCESS-phase cycles without pready before forced abort; 0 disables the timeout
- IDX_W, $clog2(NUM_REQ), grant index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened write data, same packing
- req_done  out  NUM_REQ  one-cycle completion pulse to the served requester
- rsp_rdata  out  DATA_W  read data, valid when any req_done bit is 1
- rsp_err  out  1  error flag (pslverr or timeout), valid with req_done
- grant_id  out  IDX_W  index of the requester currently owning the bus
- busy  out  1  high whenever the FSM is not in IDLE
- paddr  out  ADDR_W  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. On reset:
  - State IDLE; rr_ptr=0.
  - paddr, pwdata, pwrite, psel, penable all 0.
  - req_done=0, rsp_rdata=0, rsp_err=0, grant_id=0, busy=0.
- All outputs are registered.
- FSM states are IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If any req_valid bit is set, pick the first set bit scanning upward from rr_ptr with wrap.
  - Latch that requester's addr/wdata/write into paddr/pwdata/pwrite, and set grant_id.
  - Set psel=1, penable=0, then go to SETUP.
  - No request: stay in IDLE with outputs unchanged.
- SETUP (one cycle): set penable=1, go to ACCESS.
- ACCESS:
  - paddr, pwdata, pwrite and psel are held stable.
  - Timeout counter increments on each cycle with pready=0.
  - If pready=1:
    - Read: rsp_rdata<=prdata. Write: rsp_rdata<=0.
    - rsp_err<=pslverr.
    - psel=0, penable=0, then go to DONE.
  - Else if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1:
    - Abort: psel=0, penable=0, rsp_rdata<=0, rsp_err<=1, then go to DONE.
- DONE (one cycle):
  - req_done[grant_id]=1; all other req_done bits are 0.
  - rr_ptr<=(grant_id+1) mod NUM_REQ.
  - No arbitration occurs in this cycle. Go to IDLE.
- Timeout counter clears on entry to ACCESS. Its width is sufficient for TIMEOUT_CYCLES.
- Zero-wait latency: req_valid sampled in IDLE at cycle 0 gives psel=1 in cycle 1, penable=1 in cycle 2, req_done in cycle 3. Peak throughput is one transfer per 4 cycles.
- Requester contract:
  - Hold req_valid, addr, wdata and write stable until req_done is seen.
  - Deassert req_valid, or present a new request, on the edge after req_done.
  - A deassert before done is a protocol violation. It is ignored because the payload is latched in IDLE.
- rsp_rdata and rsp_err hold their values until the next DONE.
- Simultaneous requests: strict round-robin. A continuously requesting agent cannot starve the others; each waits at most NUM_REQ-1 transfers.
- Wrap-around: rr_ptr wraps from NUM_REQ-1 to 0.
- busy=1 in SETUP, ACCESS and DONE.
- Reset mid-transfer: all state and outputs clear asynchronously and the transfer is dropped with no req_done. Arbitration restarts with requester 0 having priority.
- A pslverr that arrives with pready=0 is ignored; only the value coincident with pready is used.

Test Plan:
- Single read: NUM_REQ=2, req0 reads 0x04, slave pready=1, prdata=0x00000003 -> psel rises cycle 1, penable cycle 2, req_done=2'b01 cycle 3, rsp_rdata=0x3, rsp_err=0.
- Contention: req0 writes 0x00 with data 0xA5, req1 reads 0x08, same cycle, rr_ptr=0 -> req0 APB write to 0x00 first, then req1 read. rr_ptr is 0 after the second done (wrap). Both dones occur within 8 cycles.
- Wait states: req1 writes 0x0C with data 0x1; pready low for 3 ACCESS cycles -> paddr/pwdata/penable stable throughout, req_done[1] in cycle 6, rsp_err=0.
- Timeout: TIMEOUT_CYCLES=8, pready held 0 -> psel/penable drop after 8 ACCESS cycles, req_done pulses, rsp_err=1, rsp_rdata=0.
- Slave error plus fairness: req0 and req1 both held continuously valid, slave returns pslverr=1 with pready=1 on every transfer -> grants alternate 0,1,0,1, each done has rsp_err=1.
- Reset during ACCESS: rst_n low while penable=1 -> psel, penable and busy are 0 immediately, no req_done. After release with req0 and req1 both valid, req0 is granted first.

Source files
------------

// File: rtl/apb_regfile_arbiter.sv
// apb_regfile_arbiter: round-robin APB master that shares one register-file
// slave port between NUM_REQ internal requesters. Each transfer runs through
// IDLE -> SETUP -> ACCESS -> DONE. A pready timeout bounds hung transfers.
module apb_regfile_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_done,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic [IDX_W-1:0]            grant_id,
    output logic                        busy,
    output logic [ADDR_W-1:0]           paddr,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [DATA_W-1:0]           pwdata,
    input  logic [DATA_W-1:0]           prdata,
    input  logic                        pready,
    input  logic                        pslverr
);

    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TO_W-1:0]      tmo_q, tmo_d;
    logic [ADDR_W-1:0]    paddr_q, paddr_d;
    logic [DATA_W-1:0]    pwdata_q, pwdata_d;
    logic                 pwrite_q, pwrite_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic [NUM_REQ-1:0]   req_done_q, req_done_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [IDX_W-1:0]     grant_id_q, grant_id_d;
    logic                 busy_q, busy_d;

    logic                 found;
    logic [IDX_W-1:0]     pick;
    logic [IDX_W-1:0]     cand;

    // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state and registered-output logic for the APB sequencer.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        tmo_d       = tmo_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        req_done_d  = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        grant_id_d  = grant_id_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    paddr_d    = req_addr[int'(pick)*ADDR_W +: ADDR_W];
                    pwdata_d   = req_wdata[int'(pick)*DATA_W +: DATA_W];
                    pwrite_d   = req_write[pick];
                    grant_id_d = pick;
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                tmo_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rsp_rdata_d           = pwrite_q ? '0 : prdata;
                    rsp_err_d             = pslverr;
                    psel_d                = 1'b0;
                    penable_d             = 1'b0;
                    req_done_d[grant_id_q] = 1'b1;
                    state_d               = DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TO_LAST)) begin
                    // Slave never answered: abort and report an error.
                    rsp_rdata_d           = '0;
                    rsp_err_d             = 1'b1;
                    psel_d                = 1'b0;
                    penable_d             = 1'b0;
                    req_done_d[grant_id_q] = 1'b1;
                    state_d               = DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE: begin
                // req_done is visible this cycle; the requester updates its
                // request on the closing edge, so no arbitration here.
                rr_ptr_d = (grant_id_q == LAST_IDX) ? '0 : grant_id_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            tmo_q       <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            req_done_q  <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            grant_id_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            tmo_q       <= tmo_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            req_done_q  <= req_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            grant_id_q  <= grant_id_d;
            busy_q      <= busy_d;
        end
    end

    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pwrite    = pwrite_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign req_done  = req_done_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_apb_regfile_arbiter.sv
// Directed bench for apb_regfile_arbiter with two requesters and an
// eight-cycle pready timeout; the bench plays the APB slave itself.
module tb_apb_regfile_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int IDX_W   = 1;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NUM_REQ-1:0]         req_valid = '0;
    logic [NUM_REQ-1:0]         req_write = '0;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0]  req_wdata = '0;
    logic [NUM_REQ-1:0]         req_done;
    logic [DATA_W-1:0]          rsp_rdata;
    logic                       rsp_err;
    logic [IDX_W-1:0]           grant_id;
    logic                       busy;
    logic [ADDR_W-1:0]          paddr;
    logic                       psel;
    logic                       penable;
    logic                       pwrite;
    logic [DATA_W-1:0]          pwdata;
    logic [DATA_W-1:0]          prdata = '0;
    logic                       pready = 1'b1;
    logic                       pslverr = 1'b0;

    int total = 0;
    int bad   = 0;

    apb_regfile_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(8), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .grant_id(grant_id), .busy(busy),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        total++; if (psel !== 1'b0 || penable !== 1'b0) begin bad++; $display("FAIL rst_apb got=%b%b exp=00", psel, penable); end
        total++; if (paddr !== 8'h0 || pwdata !== 32'h0 || pwrite !== 1'b0) begin bad++; $display("FAIL rst_payload got=%h/%h/%b exp=0", paddr, pwdata, pwrite); end
        total++; if (req_done !== 2'b00 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp got=%b/%h/%b exp=0", req_done, rsp_rdata, rsp_err); end
        total++; if (grant_id !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_ctl got=%b/%b exp=0/0", grant_id, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        req_valid = 2'b01; req_write = 2'b00; req_addr[7:0] = 8'h04;
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h0000_0003;
        total++; if (psel !== 1'b0) begin bad++; $display("FAIL rd_psel_c0 got=%b exp=0", psel); end
        tick();
        total++; if (psel !== 1'b1 || penable !== 1'b0) begin bad++; $display("FAIL rd_setup got=%b%b exp=10", psel, penable); end
        total++; if (paddr !== 8'h04 || pwrite !== 1'b0 || grant_id !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rd_setup_payload got=%h/%b/%b/%b exp=04/0/0/1", paddr, pwrite, grant_id, busy); end
        tick();
        total++; if (psel !== 1'b1 || penable !== 1'b1) begin bad++; $display("FAIL rd_access got=%b%b exp=11", psel, penable); end
        tick();
        total++; if (req_done !== 2'b01) begin bad++; $display("FAIL rd_done got=%b exp=01", req_done); end
        total++; if (rsp_rdata !== 32'h3 || rsp_err !== 1'b0) begin bad++; $display("FAIL rd_rsp got=%h/%b exp=3/0", rsp_rdata, rsp_err); end
        total++; if (psel !== 1'b0 || penable !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rd_done_bus got=%b%b%b exp=001", psel, penable, busy); end
        tick();
        req_valid = 2'b00;
        total++; if (req_done !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL rd_idle got=%b/%b exp=00/0", req_done, busy); end
        total++; if (rsp_rdata !== 32'h3) begin bad++; $display("FAIL rd_hold got=%h exp=3", rsp_rdata); end
        tick();
    endtask

    task automatic test_wait_states();
        req_valid = 2'b10; req_write = 2'b10;
        req_addr[15:8] = 8'h0C; req_wdata[63:32] = 32'h1;
        pready = 1'b0; pslverr = 1'b1;
        tick(); // cycle 1
        total++; if (grant_id !== 1'b1 || psel !== 1'b1 || penable !== 1'b0) begin bad++; $display("FAIL ws_setup got=%b/%b%b exp=1/10", grant_id, psel, penable); end
        for (int c = 2; c <= 4; c++) begin
            tick();
            total++; if (paddr !== 8'h0C || pwdata !== 32'h1 || pwrite !== 1'b1 || psel !== 1'b1 || penable !== 1'b1 || req_done !== 2'b00) begin bad++; $display("FAIL ws_hold_c%0d got=%h/%h/%b/%b%b/%b", c, paddr, pwdata, pwrite, psel, penable, req_done); end
        end
        tick(); // cycle 5: slave answers
        pready = 1'b1; pslverr = 1'b0;
        total++; if (req_done !== 2'b00 || penable !== 1'b1) begin bad++; $display("FAIL ws_c5 got=%b/%b exp=00/1", req_done, penable); end
        tick(); // cycle 6
        total++; if (req_done !== 2'b10 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL ws_done got=%b/%b/%h exp=10/0/0", req_done, rsp_err, rsp_rdata); end
        tick();
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_contention();
        req_valid = 2'b11; req_write = 2'b01;
        req_addr = {8'h08, 8'h00}; req_wdata = {32'h0, 32'hA5};
        pready = 1'b1; pslverr = 1'b0; prdata = 32'hDEAD_BEEF;
        tick(); // cycle 1
        total++; if (grant_id !== 1'b0 || paddr !== 8'h00 || pwrite !== 1'b1 || pwdata !== 32'hA5) begin bad++; $display("FAIL ct_first got=%b/%h/%b/%h exp=0/00/1/a5", grant_id, paddr, pwrite, pwdata); end
        tick(); tick(); // cycle 3
        total++; if (req_done !== 2'b01 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL ct_done0 got=%b/%h exp=01/0", req_done, rsp_rdata); end
        tick(); // cycle 4
        req_valid = 2'b10;
        tick(); // cycle 5
        total++; if (grant_id !== 1'b1 || paddr !== 8'h08 || pwrite !== 1'b0 || psel !== 1'b1) begin bad++; $display("FAIL ct_second got=%b/%h/%b/%b exp=1/08/0/1", grant_id, paddr, pwrite, psel); end
        tick(); tick(); // cycle 7
        total++; if (req_done !== 2'b10 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin bad++; $display("FAIL ct_done1 got=%b/%h/%b exp=10/deadbeef/0", req_done, rsp_rdata, rsp_err); end
        tick();
        req_valid = 2'b00;
        total++; if (dut.rr_ptr_q !== 1'b0) begin bad++; $display("FAIL ct_rr_wrap got=%b exp=0", dut.rr_ptr_q); end
        tick();
    endtask

    task automatic test_timeout();
        req_valid = 2'b10; req_write = 2'b00; req_addr[15:8] = 8'h20;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h1234_5678;
        tick(); // cycle 1 SETUP
        for (int c = 2; c <= 9; c++) begin
            tick();
            total++; if (psel !== 1'b1 || penable !== 1'b1 || req_done !== 2'b00) begin bad++; $display("FAIL to_access_c%0d got=%b%b/%b exp=11/00", c, psel, penable, req_done); end
        end
        tick(); // cycle 10
        total++; if (psel !== 1'b0 || penable !== 1'b0) begin bad++; $display("FAIL to_drop got=%b%b exp=00", psel, penable); end
        total++; if (req_done !== 2'b10 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_done got=%b/%b/%h exp=10/1/0", req_done, rsp_err, rsp_rdata); end
        tick();
        req_valid = 2'b00; pready = 1'b1;
        tick();
    endtask

    task automatic test_fairness_slverr();
        logic [1:0] exp_done [4];
        exp_done[0] = 2'b01; exp_done[1] = 2'b10; exp_done[2] = 2'b01; exp_done[3] = 2'b10;
        req_valid = 2'b11; req_write = 2'b00; req_addr = {8'h14, 8'h10};
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFE_0001;
        for (int k = 0; k < 4; k++) begin
            tick(); // SETUP
            total++; if (grant_id !== exp_done[k][1] || paddr !== (exp_done[k][1] ? 8'h14 : 8'h10)) begin bad++; $display("FAIL fair_grant_%0d got=%b/%h exp=%b", k, grant_id, paddr, exp_done[k][1]); end
            tick(); tick(); // DONE
            total++; if (req_done !== exp_done[k] || rsp_err !== 1'b1) begin bad++; $display("FAIL fair_done_%0d got=%b/%b exp=%b/1", k, req_done, rsp_err, exp_done[k]); end
            tick(); // IDLE, requests still held
        end
        req_valid = 2'b00; pslverr = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        // Complete a req0 transfer so the pointer favours req1.
        req_valid = 2'b01; req_write = 2'b00; req_addr = {8'h30, 8'h2C};
        pready = 1'b1; prdata = 32'h5;
        tick(); tick(); tick(); tick();
        req_valid = 2'b10; pready = 1'b0;
        tick(); tick(); // cycle 2: ACCESS stalled
        total++; if (penable !== 1'b1 || grant_id !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b/%b exp=1/1", penable, grant_id); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (psel !== 1'b0 || penable !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rm_async got=%b%b%b exp=000", psel, penable, busy); end
        tick();
        total++; if (req_done !== 2'b00 || grant_id !== 1'b0) begin bad++; $display("FAIL rm_nodone got=%b/%b exp=00/0", req_done, grant_id); end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b11; pready = 1'b1;
        tick(); // cycle 1 after release
        total++; if (grant_id !== 1'b0 || psel !== 1'b1 || paddr !== 8'h2C) begin bad++; $display("FAIL rm_prio got=%b/%b/%h exp=0/1/2c", grant_id, psel, paddr); end
        tick(); tick();
        total++; if (req_done !== 2'b01) begin bad++; $display("FAIL rm_done got=%b exp=01", req_done); end
        tick();
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_wait_states();
        test_contention();
        test_timeout();
        test_fairness_slverr();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
